// File: rtl/dram_addr_unmapper.sv
// Rebuilds per-beat linear byte addresses from DRAM row/col/bg/bank and checks that bank/bg agree with col.
// Beat 0 is valid one cycle after accept, then one beat per cycle; outputs hold while out_valid && !out_ready.
module dram_addr_unmapper #(
  parameter int LEN_W     = 4,
  parameter int ERR_CNT_W = 16,
  parameter int CHECK_EN  = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_row,
  input  logic [9:0]           in_col,
  input  logic [1:0]           in_bg,
  input  logic [1:0]           in_bank,
  input  logic [LEN_W-1:0]     in_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_addr,
  output logic                 out_last,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_addr_q, out_addr_d;
  logic                 out_last_q, out_last_d;
  logic                 out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic        out_free;
  logic        accept;
  logic        in_err;
  logic [31:0] in_addr;
  logic [31:0] next_addr;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == IDLE) && out_free;
  assign accept   = in_valid && in_ready;

  // col owns addr[14:5]; bank and bg[0] are redundant copies of col[8:7] and col[9].
  assign in_addr   = {3'b000, in_row[12:0], in_bg[1], in_col, in_row[15:13], 2'b00};
  assign in_err    = (in_bank != in_col[8:7]) || (in_bg[0] != in_col[9]);
  assign next_addr = {out_addr_q[31:15], out_addr_q[14:5] + 10'd1, out_addr_q[4:0]};

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_addr_d  = in_addr;
          out_last_d  = (in_len == '0);
          out_err_d   = (CHECK_EN != 0) && in_err;
          if ((CHECK_EN != 0) && in_err && (err_count_q != {ERR_CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
          end
          if (in_len != '0) begin
            state_d = BURST;
            rem_d   = in_len;
          end
        end
      end
      BURST: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_addr_d  = next_addr;
          rem_d       = rem_q - 1'b1;
          out_last_d  = (rem_q == LEN_W'(1));
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_dram_addr_unmapper.sv
// Directed bench for dram_addr_unmapper; a narrow error counter keeps saturation reachable quickly.
module tb_dram_addr_unmapper;

  localparam int LEN_W     = 4;
  localparam int ERR_CNT_W = 4;

  logic                 sys_clk;
  logic                 sys_rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          in_row;
  logic [9:0]           in_col;
  logic [1:0]           in_bg;
  logic [1:0]           in_bank;
  logic [LEN_W-1:0]     in_len;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_addr;
  logic                 out_last;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  dram_addr_unmapper #(
    .LEN_W    (LEN_W),
    .ERR_CNT_W(ERR_CNT_W),
    .CHECK_EN (1)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .in_col   (in_col),
    .in_bg    (in_bg),
    .in_bank  (in_bank),
    .in_len   (in_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_last (out_last),
    .out_err  (out_err),
    .err_count(err_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_req(input logic [15:0] row, input logic [9:0] col,
                         input logic [1:0] bg, input logic [1:0] bank,
                         input logic [LEN_W-1:0] len);
    in_row  = row;
    in_col  = col;
    in_bg   = bg;
    in_bank = bank;
    in_len  = len;
  endtask

  // Present a request, wait (bounded) for in_ready, and let it be accepted on the next edge.
  task automatic send(input logic [15:0] row, input logic [9:0] col,
                      input logic [1:0] bg, input logic [1:0] bank,
                      input logic [LEN_W-1:0] len);
    int n;
    set_req(row, col, bg, bank, len);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) check("send_rdy_timeout", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Check the beat currently on the output, then consume it (out_ready assumed 1).
  task automatic expect_beat(input string tag, input logic [31:0] addr,
                             input logic last, input logic err);
    check({tag, "_vld"},  {31'd0, out_valid}, 32'd1);
    check({tag, "_addr"}, out_addr, addr);
    check({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
    check({tag, "_err"},  {31'd0, out_err}, {31'd0, err});
    step();
  endtask

  initial begin
    sys_rst   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_req(16'h0, 10'h0, 2'd0, 2'd0, '0);
    step();
    step();
    check("rst_vld",   {31'd0, out_valid}, 32'd0);
    check("rst_addr",  out_addr, 32'd0);
    check("rst_last",  {31'd0, out_last}, 32'd0);
    check("rst_err",   {31'd0, out_err}, 32'd0);
    check("rst_cnt",   32'(err_count), 32'd0);
    sys_rst = 1'b0;
    step();
    check("rst_rdy",   {31'd0, in_ready}, 32'd1);

    // Single beat, consistent bank/bg.
    send(16'h1ABC, 10'h2BF, 2'd3, 2'd1, 4'd0);
    expect_beat("t1", 32'h1ABCD7E0, 1'b1, 1'b0);
    check("t1_cnt", 32'(err_count), 32'd0);
    check("t1_idle_vld", {31'd0, out_valid}, 32'd0);

    // Three beats with column wrap.
    send(16'h0001, 10'h3FE, 2'd1, 2'd3, 4'd2);
    expect_beat("t2b0", 32'h00017FC0, 1'b0, 1'b0);
    expect_beat("t2b1", 32'h00017FE0, 1'b0, 1'b0);
    expect_beat("t2b2", 32'h00010000, 1'b1, 1'b0);
    check("t2_done_vld", {31'd0, out_valid}, 32'd0);

    // Bank mismatch, then saturate the counter at 15.
    send(16'h1ABC, 10'h2BF, 2'd3, 2'd0, 4'd0);
    check("t3_cnt1", 32'(err_count), 32'd1);
    expect_beat("t3", 32'h1ABCD7E0, 1'b1, 1'b1);
    for (int i = 0; i < 14; i++) send(16'h1ABC, 10'h2BF, 2'd3, 2'd0, 4'd0);
    check("t3_cnt15", 32'(err_count), 32'd15);
    send(16'h1ABC, 10'h2BF, 2'd3, 2'd0, 4'd0);
    check("t3_sat", 32'(err_count), 32'd15);
    expect_beat("t3sat", 32'h1ABCD7E0, 1'b1, 1'b1);

    // High row bits land in addr[4:2].
    send(16'hE000, 10'h000, 2'd0, 2'd0, 4'd0);
    expect_beat("t4", 32'h0000001C, 1'b1, 1'b0);

    // Backpressure after beat 0, with the next request waiting behind it.
    send(16'h0001, 10'h3FE, 2'd1, 2'd3, 4'd2);
    check("t5b0_addr", out_addr, 32'h00017FC0);
    out_ready = 1'b0;
    set_req(16'h1ABC, 10'h2BF, 2'd3, 2'd1, 4'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_hold_vld",  {31'd0, out_valid}, 32'd1);
      check("t5_hold_addr", out_addr, 32'h00017FC0);
      check("t5_hold_last", {31'd0, out_last}, 32'd0);
      check("t5_hold_rdy",  {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    check("t5_burst_rdy", {31'd0, in_ready}, 32'd0);
    step();
    check("t5b1_addr", out_addr, 32'h00017FE0);
    check("t5b1_last", {31'd0, out_last}, 32'd0);
    step();
    check("t5b2_addr", out_addr, 32'h00010000);
    check("t5b2_last", {31'd0, out_last}, 32'd1);
    check("t5_b2b_rdy", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    expect_beat("t5next", 32'h1ABCD7E0, 1'b1, 1'b0);
    check("t5_cnt", 32'(err_count), 32'd15);

    // Reset in the middle of an 8-beat burst.
    send(16'h0002, 10'h010, 2'd0, 2'd0, 4'd7);
    expect_beat("t6b0", 32'h00020200, 1'b0, 1'b0);
    expect_beat("t6b1", 32'h00020220, 1'b0, 1'b0);
    check("t6b2_addr", out_addr, 32'h00020240);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    check("t6_rst_vld",  {31'd0, out_valid}, 32'd0);
    check("t6_rst_addr", out_addr, 32'd0);
    check("t6_rst_cnt",  32'(err_count), 32'd0);
    check("t6_rst_rdy",  {31'd0, in_ready}, 32'd1);
    send(16'hE000, 10'h000, 2'd0, 2'd0, 4'd0);
    expect_beat("t6new", 32'h0000001C, 1'b1, 1'b0);
    check("t6_end_vld", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
